// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcodes, ALU op classes, the decoded control
// bundle and the register-read predicates used by hazard detection.
package riscv_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;
    localparam logic [1:0] ALUOP_LUI  = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    // LUI is the only class known not to read rs1; every other class is assumed to.
    function automatic logic reads_rs1(input logic [1:0] alu_op);
        return alu_op != ALUOP_LUI;
    endfunction

    // rs2 is read when the ALU takes it as an operand or a store writes it to memory.
    function automatic logic reads_rs2(input logic alu_src, input logic mem_write);
        return !alu_src || mem_write;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: flags an ID instruction that reads the register a
// load currently in EX is about to write.
module hazard_detect
    import riscv_pkg::*;
(
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [1:0]           id_alu_op,
    input  logic                 id_alu_src,
    input  logic                 id_mem_write,
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    output logic                 hazard
);

    logic rs1_dep;
    logic rs2_dep;

    assign rs1_dep = reads_rs1(id_alu_op) && (ex_rd == id_rs1);
    assign rs2_dep = reads_rs2(id_alu_src, id_mem_write) && (ex_rd == id_rs2);

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign hazard = id_valid && ex_valid && ex_mem_read && (ex_rd != '0)
                    && (rs1_dep || rs2_dep);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and branch-flush bubbles.
// Optional performance counters are built when PERF_CNT_EN is defined.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [XLEN-1:0]      id_pc,
    input  logic [XLEN-1:0]      id_rs1_data,
    input  logic [XLEN-1:0]      id_rs2_data,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic [2:0]           id_funct3,
    input  logic                 id_funct7_b5,
    input  logic                 id_reg_write,
    input  logic                 id_alu_src,
    input  logic                 id_mem_read,
    input  logic                 id_mem_write,
    input  logic                 id_mem_to_reg,
    input  logic                 id_branch,
    input  logic [1:0]           id_alu_op,
    input  logic                 flush_ex,
    output logic                 hold_if_id,
    output logic                 ex_valid,
    output logic [XLEN-1:0]      ex_pc,
    output logic [XLEN-1:0]      ex_rs1_data,
    output logic [XLEN-1:0]      ex_rs2_data,
    output logic [XLEN-1:0]      ex_imm,
    output logic [REG_IDX_W-1:0] ex_rs1,
    output logic [REG_IDX_W-1:0] ex_rs2,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic [2:0]           ex_funct3,
    output logic                 ex_funct7_b5,
    output logic                 ex_reg_write,
    output logic                 ex_alu_src,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write,
    output logic                 ex_mem_to_reg,
    output logic                 ex_branch,
    output logic [1:0]           ex_alu_op,
    output logic [CNT_W-1:0]     stall_count,
    output logic [CNT_W-1:0]     flush_count
);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    logic  hazard;
    logic  bubble;

    assign id_ctrl = '{reg_write: id_reg_write, alu_src: id_alu_src, mem_read: id_mem_read,
                       mem_write: id_mem_write, mem_to_reg: id_mem_to_reg, branch: id_branch,
                       alu_op: id_alu_op};

    hazard_detect u_hazard_detect (
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_alu_op    (id_alu_op),
        .id_alu_src   (id_alu_src),
        .id_mem_write (id_mem_write),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_ctrl.mem_read),
        .ex_rd        (ex_rd),
        .hazard       (hazard)
    );

    // A flush squashes ID upstream as well, so holding it would only waste a cycle.
    assign hold_if_id = hazard && !flush_ex;
    assign bubble     = flush_ex || hazard || !id_valid;

    // NOTE: every sequential assignment is non-blocking so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            ex_valid     <= 1'b0;
            ex_ctrl      <= '0;
            ex_pc        <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_funct3    <= '0;
            ex_funct7_b5 <= 1'b0;
        end else begin
            ex_valid     <= 1'b1;
            ex_ctrl      <= id_ctrl;
            ex_pc        <= id_pc;
            ex_rs1_data  <= id_rs1_data;
            ex_rs2_data  <= id_rs2_data;
            ex_imm       <= id_imm;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rd        <= id_rd;
            ex_funct3    <= id_funct3;
            ex_funct7_b5 <= id_funct7_b5;
        end
    end

    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_branch     = ex_ctrl.branch;
    assign ex_alu_op     = ex_ctrl.alu_op;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // A flush is counted only when it actually discards an instruction in ID or EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (hold_if_id)
                stall_q <= stall_q + 1'b1;
            if (flush_ex && (ex_valid || id_valid))
                flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_count = stall_q;
    assign flush_count = flush_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core, fed by the decode-stage control unit, register file and immediate generator.
- Registers the control bundle and the operands/immediate/destination for EX.
- Contains load-use hazard detection. Inserts bubbles on stall or branch flush.
- Drives the hold signal back to the PC and IF/ID registers.

Parameters:
- XLEN, 32, datapath and PC width.
- CNT_W, 32, width of performance counters (used only with PERF_CNT_EN).

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rs1_data, id_rs2_data  in  XLEN each  register file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_funct3  in  3  instruction funct3
- id_funct7_b5  in  1  instruction bit 30
- id_reg_write, id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  control bundle
- id_alu_op  in  2  ALU op class
- flush_ex  in  1  branch/jump resolved taken in EX this cycle
- hold_if_id  out  1  stall PC and IF/ID this cycle
- ex_valid  out  1  EX slot holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered copies
- ex_rs1, ex_rs2, ex_rd  out  5 each
- ex_funct3  out  3
- ex_funct7_b5  out  1
- ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each
- ex_alu_op  out  2
- stall_count, flush_count  out  CNT_W each  performance counters

Behaviour:
- Reset: every ex_* output is 0, ex_valid is 0, and both counters are 0. hold_if_id is combinational, so it is 0 while ex_valid is 0.
- Latency: 1 cycle from id_* to ex_*. hold_if_id is combinational in the same cycle.
- Load-use detection (combinational):
  - hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((uses_rs1 & ex_rd == id_rs1) | (uses_rs2 & ex_rd == id_rs2)).
  - uses_rs1 = (id_alu_op != 2'b11). LUI does not read rs1. All other classes are treated conservatively as reading rs1.
  - uses_rs2 = ~id_alu_src | id_mem_write.
- hold_if_id = hazard & ~flush_ex.
- Next-state priority, highest first:
  1. rst: all outputs cleared.
  2. flush_ex = 1: bubble. ID is also squashed upstream, so no hold.
  3. hazard = 1: bubble. ID instruction stays in IF/ID and re-presents next cycle.
  4. id_valid = 0: bubble.
  5. Otherwise: load all id_* into ex_* and set ex_valid = 1.
- Bubble: ex_valid and all ex control bits are 0, and all datapath fields are zeroed (deterministic waveforms).
- A stall lasts exactly 1 cycle per load. After the bubble, ex_mem_read is 0, so the hazard clears automatically.
- Back-to-back loads with a dependent load each stall once. No multi-cycle stall exists.
- Dependency on x0 never stalls.
- flush_ex and hazard in the same cycle: flush wins, and hold_if_id is 0.
- Reset mid-stall: the next cycle shows ex_valid = 0 and hold_if_id = 0.

Optional Feature:
- Macro: PERF_CNT_EN.
- With it defined:
  - stall_count increments on every cycle with hold_if_id = 1.
  - flush_count increments on every cycle with flush_ex = 1 while ex_valid = 1 or id_valid = 1.
  - Both wrap modulo 2^CNT_W and are cleared by rst.
- Without it: both ports are tied to 0 and no counter flops exist. The port list is unchanged.

Decomposition:
- Shared package riscv_pkg:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - ALU op class constants ALUOP_ADD = 2'b00, ALUOP_BR = 2'b01, ALUOP_FUNC = 2'b10, ALUOP_LUI = 2'b11;
  - REG_IDX_W = 5.
- One combinational sub-module, hazard_detect, computes hazard from the ID indices/controls and the registered EX rd/mem_read/valid.
- The pipeline register stays in id_ex_stage.

Test Plan:
- Reset: assert rst 2 cycles with all id_* nonzero -> all ex_* = 0, ex_valid = 0, hold_if_id = 0, counters = 0.
- Pass-through: ADD x3,x1,x2 with id_valid = 1, alu_op = 10, rs1_data = 5, rs2_data = 7 -> next cycle ex_valid = 1, ex_rd = 3, ex_rs1_data = 5, ex_rs2_data = 7, ex_reg_write = 1.
- Load-use: LW x5 then ADD x6,x5,x1 -> hold_if_id = 1 for one cycle, one bubble (ex_valid = 0), then the ADD enters EX; stall_count = 1 with PERF_CNT_EN.
- No false stall:
  - LW x5 then ADDI x6,x0,1 -> no hold;
  - LW x0 then ADD x6,x0,x0 -> no hold;
  - LW x5 then LUI x5 -> no hold.
- Flush priority: flush_ex = 1 with a load-use hazard pending -> hold_if_id = 0, next ex_valid = 0, flush_count increments by 1.
- Store rs2 dependency: LW x7 then SW x7,0(x2) -> 1-cycle stall. Same with BEQ x1,x7 -> 1-cycle stall.
